i2c_temp_responder: RTL and testbench
=====================================

Name: i2c_temp_responder

Overview:
- I2C target (responder) emulating a MAX30205-class temperature sensor; the far end of our I2C master/temperature controller path.
- Serves the register map TEMP/CONFIG/THYST/TOS over SCL/SDA from a 16-bit temperature input and drives an over-temperature flag.
- Used as the bench/loopback model for the master and as an FPGA-side sensor stand-in. SDA tristate lives in the parent.

Parameters:
- SLAVE_ADDR, 7'h48, 7-bit address this block answers to.
- SYNC_STAGES, 2, flip-flop stages on scl_i/sda_i before edge detection (minimum 2).
- THYST_RST, 16'h4B00, THYST reset value (75.0 C).
- TOS_RST, 16'h5000, TOS reset value (80.0 C).

Ports:
- clk  in  1  system clock; must be at least 10x the SCL frequency.
- rst  in  1  reset, synchronous, active-high.
- scl_i  in  1  SCL pad input.
- sda_i  in  1  SDA pad input.
- sda_oe  out  1  1 = pull SDA low; the parent builds the open-drain pad.
- temp_in  in  16  signed temperature, 1/256 C LSB.
- cfg_out  out  8  CONFIG register.
- thyst_out  out  16  THYST register.
- tos_out  out  16  TOS register.
- os  out  1  over-temperature flag, comparator mode.
- wr_strobe  out  1  one-cycle pulse when a register commits.
- wr_ptr  out  2  pointer of the committed register; valid with wr_strobe.
- busy  out  1  high from address match until STOP or end of transaction.

Behaviour:
- Reset values: sda_oe=0, cfg_out=0x00, thyst_out=THYST_RST, tos_out=TOS_RST, os=0, wr_strobe=0, wr_ptr=0, busy=0, pointer=0, FSM=IDLE.
- A reset mid-transaction releases SDA on that clock edge. No register update occurs.
- Synchronizer: SYNC_STAGES flops, then one compare flop. A pad edge is seen SYNC_STAGES+1 clk later.
- Data is sampled on the detected SCL rise. sda_oe changes only on the detected SCL fall.
- START is SDA fall while SCL is high; STOP is SDA rise while SCL is high. Both are detected in every state, including mid-byte.
  - START enters ADDR and releases SDA.
  - STOP enters IDLE and clears busy.
  - A partial byte never commits.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits MSB first.
    - addr[7:1] == SLAVE_ADDR: go to ADDR_ACK and set busy.
    - Otherwise: go to IDLE and never drive SDA.
  - ADDR_ACK: drive low for one SCL period.
    - R/W=0: go to PTR.
    - R/W=1: snapshot temp_in into the read shadow at the ACK SCL fall, then go to RD_DATA.
  - PTR: shift 8 bits.
    - Value <= 0x03: pointer <= value[1:0], ACK, then WR_DATA.
    - Value > 0x03: NACK (release SDA), go to IDLE.
  - WR_DATA / WR_ACK: shift each byte, then ACK it.
    - CONFIG: every byte commits to cfg_out.
    - THYST/TOS: first byte is the MSB into a holding register; second byte (LSB) commits the 16-bit value; third byte is an MSB again (byte index wraps).
    - TEMP (ptr 0): bytes are ACKed and discarded, with no strobe.
    - Each commit pulses wr_strobe and sets wr_ptr in the cycle after the ACK-bit SCL rise.
  - RD_DATA: shift out the MSB then the LSB of the selected register, MSB first.
    - TEMP reads come from the shadow, so the two bytes never tear.
    - CONFIG returns the same byte for every read byte.
    - After the LSB, the next byte wraps to the MSB. The pointer does not auto-increment.
  - RD_ACK: release SDA and sample the master's bit at the SCL rise.
    - 0 (ACK): continue in RD_DATA.
    - 1 (NACK): go to IDLE with busy low; STOP is still accepted.
- Repeated START after a pointer write keeps the pointer. A read then returns the newly pointed register.
- os (comparator), evaluated every clk with signed compares:
  - Set when temp_in > tos_out.
  - Cleared when temp_in < thyst_out.
  - Otherwise holds.
  - If tos_out <= thyst_out and both conditions are true, set wins.
- A write to TOS/THYST takes effect on os the cycle after the commit.

Decomposition:
- Package max30205_pkg holds:
  - pointer constants PTR_TEMP=0, PTR_CFG=1, PTR_THYST=2, PTR_TOS=3;
  - the state enum;
  - THYST/TOS reset constants.
- Sub-module i2c_line_sync: synchronizer plus scl_rise/scl_fall/start/stop pulse generation, parameterised by SYNC_STAGES.
- The FSM, register file and comparator stay in i2c_temp_responder.

Test Plan:
- Reads:
  - Write pointer 0x00, then repeated START read of 2 bytes with temp_in=16'h2480 -> bytes 0x24, 0x80.
  - A 3rd byte ACKed by the master returns 0x24.
  - Master NACK releases SDA and busy drops.
- Writes:
  - Write ptr 0x03, data 0x51, 0x00 -> tos_out=16'h5100, one wr_strobe with wr_ptr=3.
  - Read back -> 0x51, 0x00.
- Addressing:
  - Address 7'h49 -> sda_oe never asserts and busy stays 0.
  - Pointer 0x07 -> pointer byte NACKed and the registers are unchanged.
- Comparator:
  - temp_in ramps 0x4A00 -> 0x5100 -> 0x4C00 -> 0x4A00 with reset limits -> os rises at 0x5100, holds at 0x4C00, falls at 0x4A00.
- Interruptions:
  - STOP after 4 bits of the THYST LSB -> thyst_out unchanged, no wr_strobe.
  - rst asserted during RD_DATA while driving 0 -> sda_oe=0 next cycle, all outputs at reset values.
- Snapshot:
  - temp_in changes from 0x2480 to 0x25FF between the MSB and LSB of a read -> bytes 0x24, 0x80.

Source files
------------

// File: rtl/max30205_pkg.sv
// max30205_pkg: register pointers, limit reset values and FSM states for the MAX30205-style responder
package max30205_pkg;
    localparam logic [1:0] PTR_TEMP  = 2'd0;
    localparam logic [1:0] PTR_CFG   = 2'd1;
    localparam logic [1:0] PTR_THYST = 2'd2;
    localparam logic [1:0] PTR_TOS   = 2'd3;
    localparam logic [15:0] THYST_RST_DEF = 16'h4B00;
    localparam logic [15:0] TOS_RST_DEF   = 16'h5000;
    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
    } state_t;
endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronises SCL/SDA and flags SCL edges plus START/STOP conditions
// Ports: clk, rst (sync, active-high); scl_i/sda_i raw pads; sda synced level;
//        scl_rise/scl_fall/start/stop single-cycle pulses.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
    logic scl, scl_q, sda_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_sr <= '1;
            sda_sr <= '1;
            scl_q  <= 1'b1;
            sda_q  <= 1'b1;
        end else begin
            scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl_i};
            sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_i};
            scl_q  <= scl;
            sda_q  <= sda;
        end
    end
    assign scl      = scl_sr[SYNC_STAGES-1];
    assign sda      = sda_sr[SYNC_STAGES-1];
    assign scl_rise = scl & ~scl_q;
    assign scl_fall = ~scl & scl_q;
    // SCL must be high both before and after the SDA edge to count as START/STOP
    assign start    = scl & scl_q & sda_q & ~sda;
    assign stop     = scl & scl_q & ~sda_q & sda;
endmodule

// File: rtl/i2c_temp_responder.sv
// i2c_temp_responder: I2C target emulating a MAX30205 temperature sensor (TEMP/CONFIG/THYST/TOS)
// Ports: clk, rst (sync, active-high); scl_i/sda_i pads; sda_oe pulls SDA low;
//        temp_in signed 1/256 C; cfg_out/thyst_out/tos_out registers; os comparator flag;
//        wr_strobe/wr_ptr register commit; busy while addressed.
module i2c_temp_responder
    import max30205_pkg::*;
#(
    parameter logic [6:0]  SLAVE_ADDR  = 7'h48,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] THYST_RST   = THYST_RST_DEF,
    parameter logic [15:0] TOS_RST     = TOS_RST_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_i,
    input  logic        sda_i,
    output logic        sda_oe,
    input  logic [15:0] temp_in,
    output logic [7:0]  cfg_out,
    output logic [15:0] thyst_out,
    output logic [15:0] tos_out,
    output logic        os,
    output logic        wr_strobe,
    output logic [1:0]  wr_ptr,
    output logic        busy
);
    logic sda, scl_rise, scl_fall, start, stop;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [7:0] sr, sr_n, hold, hold_n, cfg_n, rd_byte;
    logic [1:0] ptr, ptr_n, wr_ptr_n;
    logic wr_idx, wr_idx_n, rd_idx, rd_idx_n, oe_n, busy_n, strobe_n, os_n;
    logic [15:0] shadow, shadow_n, thyst_n, tos_n, rd_word;

    i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i), .sda(sda),
        .scl_rise(scl_rise), .scl_fall(scl_fall), .start(start), .stop(stop)
    );

    // The first read bit is driven on the same fall that loads the shadow, so bypass it then
    assign rd_word = ptr == PTR_TEMP ? (state == ADDR_ACK ? temp_in : shadow) :
                     ptr == PTR_CFG ? {cfg_out, cfg_out} :
                     ptr == PTR_THYST ? thyst_out : tos_out;
    assign rd_byte = rd_idx ? rd_word[7:0] : rd_word[15:8];

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sr        <= '0;
            ptr       <= PTR_TEMP;
            hold      <= '0;
            wr_idx    <= 1'b0;
            rd_idx    <= 1'b0;
            shadow    <= '0;
            cfg_out   <= '0;
            thyst_out <= THYST_RST;
            tos_out   <= TOS_RST;
            os        <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            wr_strobe <= 1'b0;
            wr_ptr    <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sr        <= sr_n;
            ptr       <= ptr_n;
            hold      <= hold_n;
            wr_idx    <= wr_idx_n;
            rd_idx    <= rd_idx_n;
            shadow    <= shadow_n;
            cfg_out   <= cfg_n;
            thyst_out <= thyst_n;
            tos_out   <= tos_n;
            os        <= os_n;
            sda_oe    <= oe_n;
            busy      <= busy_n;
            wr_strobe <= strobe_n;
            wr_ptr    <= wr_ptr_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        sr_n     = sr;
        ptr_n    = ptr;
        hold_n   = hold;
        wr_idx_n = wr_idx;
        rd_idx_n = rd_idx;
        shadow_n = shadow;
        cfg_n    = cfg_out;
        thyst_n  = thyst_out;
        tos_n    = tos_out;
        oe_n     = sda_oe;
        busy_n   = busy;
        strobe_n = 1'b0;
        wr_ptr_n = wr_ptr;
        // Set beats clear when the limits overlap
        os_n = $signed(temp_in) > $signed(tos_out) ? 1'b1 :
               $signed(temp_in) < $signed(thyst_out) ? 1'b0 : os;
        if (start) begin
            state_n  = ADDR;
            cnt_n    = '0;
            rd_idx_n = 1'b0;
            oe_n     = 1'b0;
        end else if (stop) begin
            state_n = IDLE;
            oe_n    = 1'b0;
            busy_n  = 1'b0;
        end else begin
            case (state)
                ADDR, PTR, WR_DATA: begin
                    if (scl_rise && cnt != 4'd8) begin
                        sr_n  = {sr[6:0], sda};
                        cnt_n = cnt + 4'd1;
                    end
                    // Byte complete: decide ACK/NACK on the fall after the 8th bit
                    if (scl_fall && cnt == 4'd8) begin
                        cnt_n = '0;
                        if (state == ADDR) begin
                            state_n = sr[7:1] == SLAVE_ADDR ? ADDR_ACK : IDLE;
                            oe_n    = sr[7:1] == SLAVE_ADDR;
                            busy_n  = sr[7:1] == SLAVE_ADDR;
                        end else if (state == PTR) begin
                            state_n = sr <= 8'h03 ? PTR_ACK : IDLE;
                            oe_n    = sr <= 8'h03;
                            busy_n  = sr <= 8'h03;
                            ptr_n   = sr <= 8'h03 ? sr[1:0] : ptr;
                        end else begin
                            state_n = WR_ACK;
                            oe_n    = 1'b1;
                        end
                    end
                end
                ADDR_ACK: if (scl_fall) begin
                    state_n  = sr[0] ? RD_DATA : PTR;
                    shadow_n = sr[0] ? temp_in : shadow;
                    oe_n     = sr[0] & ~rd_byte[7];
                end
                PTR_ACK: if (scl_fall) begin
                    state_n  = WR_DATA;
                    oe_n     = 1'b0;
                    wr_idx_n = 1'b0;
                end
                WR_ACK: begin
                    if (scl_rise) begin
                        wr_idx_n = ~wr_idx;
                        hold_n   = sr;
                        strobe_n = ptr == PTR_CFG || (ptr != PTR_TEMP && wr_idx);
                        wr_ptr_n = strobe_n ? ptr : wr_ptr;
                        cfg_n    = ptr == PTR_CFG ? sr : cfg_out;
                        thyst_n  = ptr == PTR_THYST && wr_idx ? {hold, sr} : thyst_out;
                        tos_n    = ptr == PTR_TOS && wr_idx ? {hold, sr} : tos_out;
                    end
                    if (scl_fall) begin
                        state_n = WR_DATA;
                        oe_n    = 1'b0;
                    end
                end
                RD_DATA: begin
                    if (scl_rise) cnt_n = cnt + 4'd1;
                    if (scl_fall) begin
                        state_n = cnt == 4'd8 ? RD_ACK : RD_DATA;
                        oe_n    = cnt != 4'd8 && !rd_byte[~cnt[2:0]];
                    end
                end
                RD_ACK: if (scl_rise) begin
                    state_n  = sda ? IDLE : RD_DATA;
                    busy_n   = ~sda;
                    cnt_n    = '0;
                    rd_idx_n = sda ? rd_idx : ~rd_idx;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_temp_responder.sv
// tb_i2c_temp_responder: bus-level master driving the responder against a register-map model
module tb_i2c_temp_responder;
    import max30205_pkg::*;
    localparam time Q = 100;
    logic clk = 0, rst = 1, scl_m = 1, sda_m = 1, sda_bus;
    logic [15:0] temp_in = 16'h0000;
    logic sda_oe, os, wr_strobe, busy;
    logic [7:0] cfg_out;
    logic [15:0] thyst_out, tos_out;
    logic [1:0] wr_ptr, last_wr_ptr = 2'd0;
    int vectors = 0, miscompares = 0, strobes = 0;
    logic oe_seen = 0, busy_seen = 0;
    logic [7:0] cfg_m;
    logic [15:0] thyst_m, tos_m;
    logic os_m;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_temp_responder dut (
        .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_oe(sda_oe),
        .temp_in(temp_in), .cfg_out(cfg_out), .thyst_out(thyst_out), .tos_out(tos_out),
        .os(os), .wr_strobe(wr_strobe), .wr_ptr(wr_ptr), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) begin
            strobes = strobes + 1;
            last_wr_ptr = wr_ptr;
        end
        if (sda_oe) oe_seen = 1;
        if (busy) busy_seen = 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic os_rule(logic cur, logic [15:0] t, logic [15:0] th, logic [15:0] to);
        return $signed(t) > $signed(to) ? 1'b1 : $signed(t) < $signed(th) ? 1'b0 : cur;
    endfunction

    function automatic logic [15:0] exp_word(logic [1:0] p, logic [15:0] t);
        return p == PTR_TEMP ? t : p == PTR_CFG ? {cfg_m, cfg_m} : p == PTR_THYST ? thyst_m : tos_m;
    endfunction

    task automatic i2c_start;
        sda_m = 1; #Q scl_m = 1; #Q sda_m = 0; #Q scl_m = 0; #Q;
    endtask

    task automatic i2c_stop;
        sda_m = 0; #Q scl_m = 1; #Q sda_m = 1; #Q;
    endtask

    task automatic bit_out(input logic b);
        sda_m = b; #Q scl_m = 1; #Q; #Q scl_m = 0; #Q;
    endtask

    task automatic bit_in(output logic b);
        sda_m = 1; #Q scl_m = 1; #Q b = sda_bus; #Q scl_m = 0; #Q;
    endtask

    task automatic wr_byte(input logic [7:0] d, output logic ack);
        logic a;
        for (int i = 7; i >= 0; i--) bit_out(d[i]);
        bit_in(a);
        ack = ~a;
    endtask

    task automatic rd_byte(output logic [7:0] d, input logic ack);
        for (int i = 7; i >= 0; i--) bit_in(d[i]);
        bit_out(~ack);
    endtask

    task automatic set_ptr(input logic [7:0] p, output logic ack);
        logic a0, a1;
        i2c_start;
        wr_byte(8'h90, a0);
        wr_byte(p, a1);
        ack = a0 & a1;
    endtask

    task automatic read_cur(output logic [15:0] w);
        logic a;
        logic [7:0] b0, b1;
        i2c_start;
        wr_byte(8'h91, a);
        rd_byte(b0, 1'b1);
        rd_byte(b1, 1'b0);
        i2c_stop;
        check("rd_addr_ack", a, 1);
        w = {b0, b1};
    endtask

    task automatic read_reg(input logic [1:0] p, output logic [15:0] w);
        logic a;
        set_ptr({6'd0, p}, a);
        check("rd_ptr_ack", a, 1);
        read_cur(w);
    endtask

    task automatic write_reg(input logic [1:0] p, input logic [15:0] v);
        logic a0, a1, a2;
        int s0;
        s0 = strobes;
        set_ptr({6'd0, p}, a0);
        wr_byte(v[15:8], a1);
        wr_byte(v[7:0], a2);
        i2c_stop;
        #20;
        if (p == PTR_CFG) cfg_m = v[7:0];
        else if (p == PTR_THYST) thyst_m = v;
        else if (p == PTR_TOS) tos_m = v;
        check("wr_acks", {a0, a1, a2}, 3'b111);
        check("wr_strobes", strobes - s0, p == PTR_CFG ? 2 : p == PTR_TEMP ? 0 : 1);
        if (p != PTR_TEMP) check("wr_ptr", last_wr_ptr, p);
        check("wr_regs", {cfg_out, thyst_out, tos_out}, {cfg_m, thyst_m, tos_m});
    endtask

    initial begin
        logic [15:0] w, v, ramp [4];
        logic ramp_os [4];
        logic a;
        logic [7:0] b;
        logic [1:0] p;
        int s0;
        ramp = '{16'h4A00, 16'h5100, 16'h4C00, 16'h4A00};
        ramp_os = '{1'b0, 1'b1, 1'b1, 1'b0};
        cfg_m = 8'h00; thyst_m = 16'h4B00; tos_m = 16'h5000; os_m = 0;
        repeat (5) @(negedge clk);
        check("reset_outs", {sda_oe, cfg_out, thyst_out, tos_out, os, wr_strobe, wr_ptr, busy},
              {1'b0, 8'h00, 16'h4B00, 16'h5000, 1'b0, 1'b0, 2'd0, 1'b0});
        rst = 0;
        #Q;
        for (int i = 0; i < 4; i++) begin
            temp_in = ramp[i];
            #50;
            check("os_ramp", os, ramp_os[i]);
        end

        temp_in = 16'h2480;
        set_ptr(8'h00, a);
        check("ptr0_ack", a, 1);
        i2c_start;
        wr_byte(8'h91, a);
        check("rd_addr_ack", a, 1);
        rd_byte(b, 1'b1); check("rd_msb", b, 8'h24);
        rd_byte(b, 1'b1); check("rd_lsb", b, 8'h80);
        rd_byte(b, 1'b0); check("rd_wrap", b, 8'h24);
        check("nack_release", {sda_oe, busy}, 2'b00);
        i2c_stop;

        write_reg(PTR_TOS, 16'h5100);
        read_reg(PTR_TOS, w);
        check("tos_readback", w, 16'h5100);

        oe_seen = 0; busy_seen = 0;
        i2c_start;
        wr_byte(8'h92, a);
        wr_byte(8'h00, a);
        i2c_stop;
        check("foreign_addr", {a, oe_seen, busy_seen}, 3'b000);

        set_ptr(8'h07, a);
        i2c_stop;
        check("bad_ptr_nack", a, 0);
        check("bad_ptr_regs", {cfg_out, thyst_out, tos_out}, {cfg_m, thyst_m, tos_m});

        s0 = strobes;
        set_ptr({6'd0, PTR_THYST}, a);
        wr_byte(8'hAA, a);
        for (int i = 0; i < 4; i++) bit_out(i[0]);
        i2c_stop;
        #20;
        check("partial_thyst", thyst_out, thyst_m);
        check("partial_strobe", strobes - s0, 0);

        temp_in = 16'h2480;
        set_ptr(8'h00, a);
        i2c_start;
        wr_byte(8'h91, a);
        rd_byte(b, 1'b1); check("snap_msb", b, 8'h24);
        temp_in = 16'h25FF;
        rd_byte(b, 1'b0); check("snap_lsb", b, 8'h80);
        i2c_stop;

        for (int i = 0; i < 6; i++) begin
            p = 2'($urandom_range(0, 3));
            v = 16'($urandom);
            write_reg(p, v);
            temp_in = 16'($urandom);
            read_reg(p, w);
            check("rand_read", w, exp_word(p, temp_in));
        end

        write_reg(PTR_THYST, 16'($urandom_range(16'h0100, 16'h6000)));
        write_reg(PTR_TOS, 16'($urandom_range(16'h0100, 16'h6000)));
        temp_in = 16'h8000;
        #50;
        os_m = 1'b0;
        check("os_init", os, os_m);
        for (int i = 0; i < 12; i++) begin
            temp_in = i % 4 == 1 ? tos_m : i % 4 == 2 ? thyst_m : 16'($urandom_range(0, 16'h6800));
            #50;
            os_m = os_rule(os_m, temp_in, thyst_m, tos_m);
            check("os_rand", os, os_m);
        end

        temp_in = 16'h0000;
        set_ptr(8'h00, a);
        i2c_start;
        wr_byte(8'h91, a);
        check("mid_read_drive", {sda_oe, busy}, 2'b11);
        rst = 1;
        #10;
        check("mid_read_reset", {sda_oe, cfg_out, thyst_out, tos_out, os, wr_strobe, wr_ptr, busy},
              {1'b0, 8'h00, 16'h4B00, 16'h5000, 1'b0, 1'b0, 2'd0, 1'b0});
        rst = 0;
        cfg_m = 8'h00; thyst_m = 16'h4B00; tos_m = 16'h5000;
        i2c_stop;
        temp_in = 16'($urandom);
        read_cur(w);
        check("post_reset_ptr", w, temp_in);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
